simon_pkt_arb: RTL and testbench
================================

SIMON_PKT_ARB -- requirements
Module: simon_pkt_arb

Interface
REQ-001 Parameter N, default 16: SIMON word width; one block is 2N bits.
REQ-002 Parameter MODE, default 4'h1: expected info[3:0] mode code.
REQ-003 Port clk  in  1: single clock; all logic samples on its rising edge.
REQ-004 Port R  in  1: reset, synchronous and active-high.
REQ-005 Port req  in  2: req[i] high means requester i has a packet word pending.
REQ-006 Port last  in  2: last[i] marks requester i's current word as the final word of its packet.
REQ-007 Port info0, info1  in  8 each: packet info byte of requester 0/1.
REQ-008 Port data0, data1  in  2N each: current block of requester 0/1.
REQ-009 Port busy_core  in  1: the shared SIMON core cannot accept a block.
REQ-010 Port gnt  out  2: one-hot grant, or zero when idle.
REQ-011 Port load  out  1: one-cycle strobe; core captures core_info/core_data.
REQ-012 Port core_info  out  8; core_data  out  2N: registered word driven to the core.
REQ-013 Port ack  out  2: one-cycle pulse to requester i when its word is consumed.
REQ-014 Port count  out  8: number of packets completed.
REQ-015 Port err  out  1: sticky mode-mismatch flag.

Function
REQ-016 FSM states IDLE, ISSUE, WAITC, RELEASE; a one-bit round-robin pointer ptr selects the priority requester.
REQ-017 IDLE: if any req, grant ptr's requester if req[ptr] is high, else the other; gnt is registered and goes to ISSUE the next cycle. With no req, stay in IDLE with gnt=0.
REQ-018 Both req high in IDLE: grant requester ptr.
REQ-019 ISSUE with busy_core=1 or req[g]=0: hold; no load, no ack.
REQ-020 ISSUE with busy_core=0 and req[g]=1: load=1 and ack[g]=1 for exactly one cycle, latch info_g/data_g into core_info/core_data, latch last[g] as end flag, then go to WAITC.
REQ-021 WAITC: stay at least one cycle, then wait until busy_core=0. Next state is RELEASE if end flag is set, else ISSUE.
REQ-022 RELEASE (one cycle): gnt=0, count increments (wrapping 255 to 0), ptr becomes the non-granted index, next state IDLE.
REQ-023 Grant never changes mid-packet; the other requester's req is ignored until RELEASE.
REQ-024 Latency: req sampled in IDLE gives the earliest load 2 cycles later.
REQ-025 core_info/core_data hold their value between loads.

Reset
REQ-026 R=1 at a clock edge: state IDLE, ptr=0, gnt=0, load=0, ack=0, core_info=0, core_data=0, count=0, err=0.
REQ-027 Reset mid-packet abandons the packet; no ack or load is issued in the reset cycle or the cycle after.

Configuration
REQ-028 Macro SIMON_MODE_CHECK_EN: when defined, in ISSUE a word with info_g[3:0] != MODE is consumed with ack[g]=1 and load=0, err is set and stays high until reset, and the FSM goes to RELEASE without incrementing count.
REQ-029 Without SIMON_MODE_CHECK_EN: no mode check; err is tied 0; every word is loaded.

Verification
REQ-030 Reset, then req=2'b01, last=2'b01, busy_core=0: gnt=01 at cycle 1, load/ack[0] at cycle 2, gnt=00 and count=1 at RELEASE.
REQ-031 After REQ-030, req=2'b11 held with single-word packets: grants alternate 10,01,10,... and count reaches 4 after four packets.
REQ-032 Three-word packet on requester 1 with busy_core high for 3 cycles after each load: exactly 3 load pulses, gnt stays 10 throughout, and req[0] is ignored until RELEASE.
REQ-033 Assert R during WAITC of a two-word packet: all outputs return to 0, ptr=0, and the packet is not counted.
REQ-034 Count wrap: 256 single-word packets: count returns to 8'h00.
REQ-035 With SIMON_MODE_CHECK_EN, info0=8'h92 and MODE=1: ack[0] pulses, load stays 0, err=1, count unchanged; the next valid packet still loads.

Source files
------------

// File: rtl/simon_pkt_arb.sv
// Two-requester round-robin packet arbiter that feeds words to one shared SIMON core.
// Optional macro SIMON_MODE_CHECK_EN: drop (ack without load) words whose info[3:0] != MODE.
module simon_pkt_arb #(
  parameter int         N    = 16,
  parameter logic [3:0] MODE = 4'h1
) (
  input  logic           clk,
  input  logic           R,
  input  logic [1:0]     req,
  input  logic [1:0]     last,
  input  logic [7:0]     info0,
  input  logic [7:0]     info1,
  input  logic [2*N-1:0] data0,
  input  logic [2*N-1:0] data1,
  input  logic           busy_core,
  output logic [1:0]     gnt,
  output logic           load,
  output logic [7:0]     core_info,
  output logic [2*N-1:0] core_data,
  output logic [1:0]     ack,
  output logic [7:0]     count,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAITC, RELEASE} state_t;

  state_t         state_q, state_d;
  logic           ptr_q, ptr_d;
  logic [1:0]     gnt_q, gnt_d;
  logic           load_q, load_d;
  logic [1:0]     ack_q, ack_d;
  logic [7:0]     core_info_q, core_info_d;
  logic [2*N-1:0] core_data_q, core_data_d;
  logic [7:0]     count_q, count_d;
  logic           end_q, end_d;
  logic           err_q, err_d;

  logic           g;
  logic [7:0]     sel_info;
  logic [2*N-1:0] sel_data;
  logic           sel_req;
  logic           sel_last;
  logic           mode_bad;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // The granted requester is fixed for the whole packet, so its index comes from gnt_q.
  assign g        = gnt_q[1];
  assign sel_info = g ? info1 : info0;
  assign sel_data = g ? data1 : data0;
  assign sel_req  = req[g];
  assign sel_last = last[g];

`ifdef SIMON_MODE_CHECK_EN
  assign mode_bad = (sel_info[3:0] != MODE);
`else
  logic unused_mode;
  assign unused_mode = ^MODE;
  assign mode_bad    = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (R) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      gnt_q       <= 2'b00;
      load_q      <= 1'b0;
      ack_q       <= 2'b00;
      core_info_q <= '0;
      core_data_q <= '0;
      count_q     <= '0;
      end_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      load_q      <= load_d;
      ack_q       <= ack_d;
      core_info_q <= core_info_d;
      core_data_q <= core_data_d;
      count_q     <= count_d;
      end_q       <= end_d;
      err_q       <= err_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = ISSUE;
      ISSUE:   if (!busy_core && sel_req) state_d = mode_bad ? RELEASE : WAITC;
      WAITC:   if (!busy_core) state_d = end_q ? RELEASE : ISSUE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    load_d      = 1'b0;
    ack_d       = 2'b00;
    core_info_d = core_info_q;
    core_data_d = core_data_q;
    count_d     = count_q;
    end_d       = end_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (|req) gnt_d = req[ptr_q] ? onehot(ptr_q) : onehot(!ptr_q);
      end
      ISSUE: begin
        if (!busy_core && sel_req) begin
          ack_d = gnt_q;
          if (mode_bad) begin
            // Dropped word: close the packet without counting it.
            err_d = 1'b1;
            gnt_d = 2'b00;
            ptr_d = !g;
          end else begin
            load_d      = 1'b1;
            core_info_d = sel_info;
            core_data_d = sel_data;
            end_d       = sel_last;
          end
        end
      end
      WAITC: begin
        if (!busy_core && end_q) begin
          gnt_d   = 2'b00;
          ptr_d   = !g;
          count_d = count_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign gnt       = gnt_q;
  assign load      = load_q;
  assign ack       = ack_q;
  assign core_info = core_info_q;
  assign core_data = core_data_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_simon_pkt_arb.sv
// Self-checking bench for simon_pkt_arb: requesters are packet queues, expectations come
// from a packet-level round-robin model.
module tb_simon_pkt_arb;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           R;
  logic [1:0]     req, last, gnt, ack;
  logic [7:0]     info0, info1, core_info, count;
  logic [2*N-1:0] data0, data1, core_data;
  logic           busy_core, load, err;

  simon_pkt_arb #(.N(N), .MODE(4'h1)) dut (
    .clk(clk), .R(R), .req(req), .last(last), .info0(info0), .info1(info1),
    .data0(data0), .data1(data1), .busy_core(busy_core), .gnt(gnt), .load(load),
    .core_info(core_info), .core_data(core_data), .ack(ack), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] info; logic [2*N-1:0] data; logic last; } word_t;
  typedef struct { logic [1:0] gnt; logic [1:0] ack; logic [7:0] info; logic [2*N-1:0] data; } ld_t;

  word_t q0[$], q1[$];
  ld_t   log_q[$];
  int    total = 0, bad = 0;
  int    ack_events, gnt_jumps, busy_mode, busy_cnt;
  logic  busy_val;
  logic [1:0] prev_gnt;

  function automatic word_t mk(input logic [7:0] info, input logic [2*N-1:0] data, input logic l);
    word_t w;
    w.info = info; w.data = data; w.last = l;
    return w;
  endfunction

  task automatic drive_inputs();
    req   = {q1.size() != 0, q0.size() != 0};
    last  = {q1.size() != 0 ? q1[0].last : 1'b0, q0.size() != 0 ? q0[0].last : 1'b0};
    info0 = q0.size() != 0 ? q0[0].info : 8'h00;
    data0 = q0.size() != 0 ? q0[0].data : '0;
    info1 = q1.size() != 0 ? q1[0].info : 8'h00;
    data1 = q1.size() != 0 ? q1[0].data : '0;
  endtask

  // One clock: observe outputs after the edge, retire acked words, present the next inputs.
  task automatic tick();
    @(posedge clk); #1;
    if (load) log_q.push_back('{gnt, ack, core_info, core_data});
    if (ack != 2'b00) ack_events++;
    if (prev_gnt != 2'b00 && gnt != 2'b00 && gnt != prev_gnt) gnt_jumps++;
    prev_gnt = gnt;
    if (ack[0] && q0.size() != 0) q0.delete(0);
    if (ack[1] && q1.size() != 0) q1.delete(0);
    case (busy_mode)
      1: busy_core = ($urandom_range(0, 2) == 0);
      2: begin
        if (load) busy_cnt = 3;
        busy_core = (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
      end
      default: busy_core = busy_val;
    endcase
    drive_inputs();
  endtask

  task automatic clear_obs();
    log_q.delete();
    ack_events = 0;
    gnt_jumps  = 0;
  endtask

  task automatic do_reset();
    R = 1'b1;
    q0.delete(); q1.delete();
    busy_mode = 0; busy_val = 1'b0; busy_cnt = 0;
    drive_inputs();
    tick(); tick();
    R = 1'b0;
    clear_obs();
  endtask

  // Run until both requesters are empty and the grant has been released, then settle in IDLE.
  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || gnt != 2'b00) && n < budget) begin
      tick();
      n++;
    end
    tick();
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL drain_timeout: ran %0d cycles, required fewer than %0d", n, budget);
    end
  endtask

  task automatic test_reset();
    R = 1'b1;
    busy_mode = 0; busy_val = 1'b0;
    q0.delete(); q1.delete();
    q0.push_back(mk(8'h21, 32'h1234_5678, 1'b1));
    drive_inputs();
    prev_gnt = 2'b00;
    tick(); tick();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    total++; if (load !== 1'b0 || ack !== 2'b00) begin bad++; $display("FAIL reset_load_ack: got %b/%b want 0/00", load, ack); end
    total++; if (core_info !== 8'h00 || core_data !== '0) begin bad++; $display("FAIL reset_core: got %h/%h want 0/0", core_info, core_data); end
    total++; if (count !== 8'h00 || err !== 1'b0) begin bad++; $display("FAIL reset_count_err: got %h/%b want 00/0", count, err); end
    q0.delete();
    R = 1'b0;
    drive_inputs();
    clear_obs();
  endtask

  task automatic test_first_packet();
    q0.push_back(mk(8'h31, 32'hA5A5_0001, 1'b1));
    drive_inputs();
    tick();
    total++; if (gnt !== 2'b01 || load !== 1'b0) begin bad++; $display("FAIL first_grant: got gnt=%b load=%b want 01/0", gnt, load); end
    tick();
    total++; if (load !== 1'b1 || ack !== 2'b01) begin bad++; $display("FAIL first_load: got load=%b ack=%b want 1/01", load, ack); end
    total++; if (core_info !== 8'h31 || core_data !== 32'hA5A5_0001) begin bad++; $display("FAIL first_data: got %h/%h want 31/a5a50001", core_info, core_data); end
    tick();
    total++; if (load !== 1'b0 || ack !== 2'b00) begin bad++; $display("FAIL first_pulse_width: got load=%b ack=%b want 0/00", load, ack); end
    total++; if (gnt !== 2'b00 || count !== 8'd1) begin bad++; $display("FAIL first_release: got gnt=%b count=%0d want 00/1", gnt, count); end
    tick();
    total++; if (core_data !== 32'hA5A5_0001) begin bad++; $display("FAIL first_hold: got %h want a5a50001", core_data); end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g [3] = '{2'b10, 2'b01, 2'b10};
    clear_obs();
    q1.push_back(mk(8'h41, 32'h0000_1111, 1'b1));
    q1.push_back(mk(8'h51, 32'h0000_2222, 1'b1));
    q0.push_back(mk(8'h61, 32'h0000_3333, 1'b1));
    drive_inputs();
    drain(100);
    total++; if (log_q.size() != 3) begin bad++; $display("FAIL alt_loads: got %0d want 3", log_q.size()); end
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      total++;
      if (log_q[i].gnt !== exp_g[i]) begin bad++; $display("FAIL alt_gnt[%0d]: got %b want %b", i, log_q[i].gnt, exp_g[i]); end
    end
    total++; if (count !== 8'd4) begin bad++; $display("FAIL alt_count: got %0d want 4", count); end
  endtask

  task automatic test_long_packet();
    do_reset();
    busy_mode = 2;
    for (int i = 0; i < 3; i++) q1.push_back(mk(8'h71 + 8'(i << 4), 32'hB000_0000 + i, i == 2));
    drive_inputs();
    tick();
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL long_grant: got %b want 10", gnt); end
    q0.push_back(mk(8'h81, 32'hC000_0000, 1'b1));
    drive_inputs();
    drain(200);
    total++; if (log_q.size() != 4) begin bad++; $display("FAIL long_loads: got %0d want 4", log_q.size()); end
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      total++;
      if (log_q[i].gnt !== 2'b10 || log_q[i].ack !== 2'b10 || log_q[i].data !== 32'hB000_0000 + i) begin
        bad++; $display("FAIL long_word[%0d]: got gnt=%b ack=%b data=%h want 10/10/%h", i, log_q[i].gnt, log_q[i].ack, log_q[i].data, 32'hB000_0000 + i);
      end
    end
    if (log_q.size() == 4) begin
      total++; if (log_q[3].gnt !== 2'b01) begin bad++; $display("FAIL long_after: got %b want 01", log_q[3].gnt); end
    end
    total++; if (gnt_jumps != 0) begin bad++; $display("FAIL long_gnt_stable: got %0d changes want 0", gnt_jumps); end
    total++; if (count !== 8'd2) begin bad++; $display("FAIL long_count: got %0d want 2", count); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    q0.push_back(mk(8'h91, 32'hD000_0000, 1'b1));
    drive_inputs();
    drain(50);
    q1.push_back(mk(8'hA1, 32'hD000_0001, 1'b0));
    q1.push_back(mk(8'hB1, 32'hD000_0002, 1'b1));
    drive_inputs();
    while (!load && n < 10) begin tick(); n++; end
    total++; if (!load) begin bad++; $display("FAIL mid_first_load: got load=0 want 1 within 10 cycles"); end
    busy_val = 1'b1; busy_core = 1'b1;
    tick();
    R = 1'b1;
    tick();
    total++; if (gnt !== 2'b00 || load !== 1'b0 || ack !== 2'b00) begin bad++; $display("FAIL mid_reset_ctl: got %b/%b/%b want 00/0/00", gnt, load, ack); end
    total++; if (core_info !== 8'h00 || core_data !== '0 || count !== 8'h00 || err !== 1'b0) begin
      bad++; $display("FAIL mid_reset_data: got %h/%h/%h/%b want all 0", core_info, core_data, count, err);
    end
    R = 1'b0;
    q0.delete(); q1.delete();
    busy_val = 1'b0; busy_core = 1'b0;
    drive_inputs();
    tick();
    total++; if (load !== 1'b0 || ack !== 2'b00) begin bad++; $display("FAIL mid_after: got %b/%b want 0/00", load, ack); end
    clear_obs();
    q0.push_back(mk(8'hC1, 32'hE000_0000, 1'b1));
    q1.push_back(mk(8'hD1, 32'hE000_0001, 1'b1));
    drive_inputs();
    drain(100);
    total++; if (log_q.size() == 0 || log_q[0].gnt !== 2'b01) begin bad++; $display("FAIL mid_ptr: first grant got %b want 01", log_q.size() ? log_q[0].gnt : 2'bxx); end
    total++; if (count !== 8'd2) begin bad++; $display("FAIL mid_count: got %0d want 2", count); end
  endtask

  task automatic test_count_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) q0.push_back(mk(8'h01, 32'(i), 1'b1));
    drive_inputs();
    drain(4000);
    total++; if (log_q.size() != 256) begin bad++; $display("FAIL wrap_loads: got %0d want 256", log_q.size()); end
    total++; if (count !== 8'h00) begin bad++; $display("FAIL wrap_count: got %h want 00", count); end
  endtask

  task automatic test_random();
    int    lens0[$], lens1[$];
    word_t w0[$], w1[$];
    ld_t   exp_q[$];
    int    np, ptr, pick, len;
    word_t w;
    do_reset();
    busy_mode = 1;
    np = 0;
    for (int r = 0; r < 2; r++) begin
      int pk = $urandom_range(3, 10);
      for (int p = 0; p < pk; p++) begin
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) begin
          w = mk({4'($urandom), 4'h1}, 32'($urandom), k == len - 1);
          if (r == 0) begin q0.push_back(w); w0.push_back(w); end
          else        begin q1.push_back(w); w1.push_back(w); end
        end
        if (r == 0) lens0.push_back(len); else lens1.push_back(len);
        np++;
      end
    end
    // Packet-level round robin: priority side wins when both wait, then priority flips.
    ptr = 0;
    while (lens0.size() != 0 || lens1.size() != 0) begin
      if (lens0.size() != 0 && lens1.size() != 0) pick = ptr;
      else pick = (lens0.size() != 0) ? 0 : 1;
      len = (pick == 0) ? lens0.pop_front() : lens1.pop_front();
      for (int k = 0; k < len; k++) begin
        w = (pick == 0) ? w0.pop_front() : w1.pop_front();
        exp_q.push_back('{pick ? 2'b10 : 2'b01, pick ? 2'b10 : 2'b01, w.info, w.data});
      end
      ptr = 1 - pick;
    end
    drive_inputs();
    drain(8000);
    total++; if (log_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_loads: got %0d want %0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      total++;
      if (log_q[i] != exp_q[i]) begin
        bad++; $display("FAIL rand_word[%0d]: got gnt=%b ack=%b info=%h data=%h want %b/%b/%h/%h", i,
          log_q[i].gnt, log_q[i].ack, log_q[i].info, log_q[i].data, exp_q[i].gnt, exp_q[i].ack, exp_q[i].info, exp_q[i].data);
      end
    end
    total++; if (count !== 8'(np)) begin bad++; $display("FAIL rand_count: got %0d want %0d", count, np); end
    total++; if (ack_events != exp_q.size() || gnt_jumps != 0) begin bad++; $display("FAIL rand_acks: got acks=%0d jumps=%0d want %0d/0", ack_events, gnt_jumps, exp_q.size()); end
  endtask

  task automatic test_mode_check();
    do_reset();
    q0.push_back(mk(8'h92, 32'hF000_0000, 1'b1));
    drive_inputs();
    drain(50);
`ifdef SIMON_MODE_CHECK_EN
    total++; if (log_q.size() != 0 || ack_events != 1) begin bad++; $display("FAIL mode_drop: got loads=%0d acks=%0d want 0/1", log_q.size(), ack_events); end
    total++; if (err !== 1'b1 || count !== 8'd0) begin bad++; $display("FAIL mode_err: got err=%b count=%0d want 1/0", err, count); end
    clear_obs();
    q0.push_back(mk(8'h31, 32'hF000_0001, 1'b1));
    drive_inputs();
    drain(50);
    total++; if (log_q.size() != 1 || count !== 8'd1 || err !== 1'b1) begin bad++; $display("FAIL mode_next: got loads=%0d count=%0d err=%b want 1/1/1", log_q.size(), count, err); end
`else
    total++; if (log_q.size() != 1 || count !== 8'd1) begin bad++; $display("FAIL nocheck_load: got loads=%0d count=%0d want 1/1", log_q.size(), count); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL nocheck_err: got %b want 0", err); end
`endif
  endtask

  initial begin
    test_reset();
    test_first_packet();
    test_alternate();
    test_long_packet();
    test_reset_mid();
    test_count_wrap();
    test_random();
    test_mode_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
